// File: rtl/block_arbiter.sv
// Round-robin arbiter sharing one `block` logic cell between two requesters, with a valid/ready result port.
// Optional self-test sweep of all 16 cell input codes is enabled by defining BLOCK_ARB_SWEEP_EN.
module block_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  opnd0,
  input  logic [1:0]  opnd1,
  input  logic [1:0]  sel0,
  input  logic [1:0]  sel1,
  output logic [1:0]  gnt,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [1:0]  rsp_data,
  input  logic        rsp_ready
`ifdef BLOCK_ARB_SWEEP_EN
  ,
  input  logic        sweep_start,
  output logic        sweep_done,
  output logic [31:0] sweep_vec
`endif
);

`ifdef BLOCK_ARB_SWEEP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2, SWEEP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
`endif

  // opnd = {I0,I1}, sel = {S0,S1}; result = {O0,O1}
  function automatic logic [1:0] cell_eval(input logic [1:0] opnd, input logic [1:0] sel);
    logic a;
    logic b;
    logic c;
    a = sel[0] | opnd[1];
    b = sel[1] & opnd[0];
    c = a ^ b;
    cell_eval = {(sel[1] ? (a | b) : c), (sel[0] ? c : (a & b))};
  endfunction

  state_t     state_r;
  logic       last_r;
  logic [3:0] op_r;
  logic       win_s;
  logic [3:0] cell_in_s;
  logic [1:0] cell_out_s;
`ifdef BLOCK_ARB_SWEEP_EN
  logic [4:0] sweep_cnt_r;
`endif

  // Round-robin winner: on a tie the requester that was not served last wins
  always_comb begin
    win_s = 1'b0;
    if (req == 2'b11) begin
      win_s = ~last_r;
    end else begin
      win_s = req[1];
    end
  end

  // Single shared cell, fed from the sweep counter while sweeping
  always_comb begin
    cell_in_s = op_r;
`ifdef BLOCK_ARB_SWEEP_EN
    if (state_r == SWEEP) begin
      cell_in_s = sweep_cnt_r[3:0];
    end else begin
      cell_in_s = op_r;
    end
`endif
  end

  assign cell_out_s = cell_eval(cell_in_s[3:2], cell_in_s[1:0]);

  // Transaction FSM with registered grant and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      last_r    <= 1'b1;
      op_r      <= 4'd0;
      gnt       <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 2'b00;
`ifdef BLOCK_ARB_SWEEP_EN
      sweep_cnt_r <= 5'd0;
      sweep_done  <= 1'b0;
      sweep_vec   <= 32'd0;
`endif
    end else begin
`ifdef BLOCK_ARB_SWEEP_EN
      sweep_done <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
`ifdef BLOCK_ARB_SWEEP_EN
          if (sweep_start) begin
            sweep_cnt_r <= 5'd0;
            state_r     <= SWEEP;
          end else
`endif
          if (req != 2'b00) begin
            op_r    <= win_s ? {opnd1, sel1} : {opnd0, sel0};
            gnt     <= win_s ? 2'b10 : 2'b01;
            last_r  <= win_s;
            state_r <= EXEC;
          end else begin
            gnt <= 2'b00;
          end
        end
        EXEC: begin
          gnt       <= 2'b00;
          rsp_data  <= cell_out_s;
          rsp_id    <= last_r;
          rsp_valid <= 1'b1;
          state_r   <= RESP;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            rsp_valid <= rsp_valid;
          end
        end
`ifdef BLOCK_ARB_SWEEP_EN
        // Counter bit 4 marks the extra cycle after code 15 that signals completion
        SWEEP: begin
          if (sweep_cnt_r[4]) begin
            sweep_done <= 1'b1;
            state_r    <= IDLE;
          end else begin
            sweep_vec[{sweep_cnt_r[3:0], 1'b0} +: 2] <= cell_out_s;
            sweep_cnt_r <= sweep_cnt_r + 5'd1;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_arbiter.sv
// Scoreboard bench for block_arbiter: a transaction model pushes expected results at grant, compared at handshake.
module tb_block_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, opnd0, opnd1, sel0, sel1, gnt, rsp_data;
  logic       rsp_valid, rsp_id, rsp_ready;
`ifdef BLOCK_ARB_SWEEP_EN
  logic        sweep_start, sweep_done;
  logic [31:0] sweep_vec;
`endif

  block_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .opnd0(opnd0), .opnd1(opnd1), .sel0(sel0), .sel1(sel1),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
`ifdef BLOCK_ARB_SWEEP_EN
    , .sweep_start(sweep_start), .sweep_done(sweep_done), .sweep_vec(sweep_vec)
`endif
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_EXEC, M_RESP} mst_t;
  typedef struct packed {logic id; logic [1:0] data;} rsp_t;

  int   errors = 0;
  int   checks = 0;
  mst_t m_st = M_IDLE;
  logic m_last = 1'b1;
  rsp_t sb[$];
  logic [1:0] gnt_log[$];
  logic       id_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_cell(input logic [1:0] op, input logic [1:0] sl);
    logic i0, i1, s0, s1, a, b, c;
    i0 = op[1]; i1 = op[0]; s0 = sl[1]; s1 = sl[0];
    a = s1 | i0;
    b = s0 & i1;
    c = a ^ b;
    return {(s0 ? (a | b) : c), (s1 ? c : (a & b))};
  endfunction

  // One clock: compare a handshaking result, step the model across the edge, check outputs after it
  task automatic tick();
    logic [1:0] r, o0, o1, s0, s1;
    logic rd, w;
    rsp_t e;
    r = req; rd = rsp_ready; o0 = opnd0; o1 = opnd1; s0 = sel0; s1 = sel1;
    if (m_st == M_RESP && rd) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        id_log.push_back(rsp_id);
      end
    end
    @(posedge clk); #1;
    case (m_st)
      M_IDLE: begin
        if (r != 2'b00) begin
          w = (r == 2'b11) ? ~m_last : r[1];
          e.id = w;
          e.data = w ? model_cell(o1, s1) : model_cell(o0, s0);
          sb.push_back(e);
          m_last = w;
          m_st = M_EXEC;
          check("gnt", 32'(gnt), w ? 32'd2 : 32'd1);
          gnt_log.push_back(gnt);
        end else begin
          check("gnt_idle", 32'(gnt), 32'd0);
        end
      end
      M_EXEC: begin
        check("gnt_exec", 32'(gnt), 32'd0);
        m_st = M_RESP;
      end
      default: begin
        check("gnt_resp", 32'(gnt), 32'd0);
        if (rd) m_st = M_IDLE;
      end
    endcase
    check("rsp_valid", 32'(rsp_valid), (m_st == M_RESP) ? 32'd1 : 32'd0);
    if (m_st == M_RESP && sb.size() > 0) begin
      check("hold_id", 32'(rsp_id), 32'(sb[0].id));
      check("hold_data", 32'(rsp_data), 32'(sb[0].data));
    end
  endtask

  // Assert reset between edges and verify outputs clear without a clock edge
  task automatic do_reset();
    req = 2'b00;
    #2; rst = 1'b1; #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_last", 32'(dut.last_r), 32'd1);
`ifdef BLOCK_ARB_SWEEP_EN
    check("rst_sweep_vec", sweep_vec, 32'd0);
    check("rst_sweep_done", 32'(sweep_done), 32'd0);
`endif
    @(posedge clk); #1; @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    m_st = M_IDLE; m_last = 1'b1; sb.delete();
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; opnd0 = 2'b00; opnd1 = 2'b00; sel0 = 2'b00; sel1 = 2'b00; rsp_ready = 1'b0;
`ifdef BLOCK_ARB_SWEEP_EN
    sweep_start = 1'b0;
`endif
    @(posedge clk); #1; rst = 1'b0;
    do_reset();

    // Single request; operands change after capture and must not affect the result
    req = 2'b01; opnd0 = 2'b01; sel0 = 2'b10;
    tick();
    check("single_gnt", 32'(gnt), 32'd1);
    req = 2'b00; opnd0 = 2'b11; sel0 = 2'b11;
    tick();
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_id", 32'(rsp_id), 32'd0);
    check("single_data", 32'(rsp_data), 32'd2);
    rsp_ready = 1'b1;
    tick(); tick();

    // Tie from reset: grants 01,10,01
    do_reset();
    req = 2'b11; rsp_ready = 1'b1;
    opnd0 = 2'b10; sel0 = 2'b01; opnd1 = 2'b11; sel1 = 2'b11;
    gnt_log.delete(); id_log.delete();
    repeat (9) tick();
    req = 2'b00;
    repeat (2) tick();
    check("tie_count", 32'(gnt_log.size()), 32'd3);
    if (gnt_log.size() == 3) begin
      check("tie_g0", 32'(gnt_log[0]), 32'd1);
      check("tie_g1", 32'(gnt_log[1]), 32'd2);
      check("tie_g2", 32'(gnt_log[2]), 32'd1);
    end
    check("tie_rsp_count", 32'(id_log.size()), 32'd3);
    if (id_log.size() == 3) begin
      check("tie_id0", 32'(id_log[0]), 32'd0);
      check("tie_id1", 32'(id_log[1]), 32'd1);
      check("tie_id2", 32'(id_log[2]), 32'd0);
    end

    // Backpressure with requester 1 pending
    req = 2'b01; opnd0 = 2'b11; sel0 = 2'b00; rsp_ready = 1'b0;
    tick();
    req = 2'b10; opnd1 = 2'b01; sel1 = 2'b01;
    repeat (6) tick();
    rsp_ready = 1'b1;
    tick();
    tick();
    check("bp_gnt1", 32'(gnt), 32'd2);
    req = 2'b00;
    repeat (3) tick();

    // Reset while in EXEC drops the result; next request served normally
    req = 2'b01; opnd0 = 2'b10; sel0 = 2'b10;
    tick();
    do_reset();
    repeat (3) tick();
    req = 2'b10; opnd1 = 2'b10; sel1 = 2'b00; rsp_ready = 1'b1;
    tick();
    req = 2'b00;
    repeat (3) tick();
    check("midop_drained", 32'(sb.size()), 32'd0);

    // Reset while holding a response
    req = 2'b01; rsp_ready = 1'b0;
    repeat (3) tick();
    do_reset();
    repeat (2) tick();

    // Random traffic with random backpressure
    repeat (80) begin
      req = 2'($urandom_range(0, 3));
      opnd0 = 2'($urandom_range(0, 3)); opnd1 = 2'($urandom_range(0, 3));
      sel0 = 2'($urandom_range(0, 3));  sel1 = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req = 2'b00; rsp_ready = 1'b1;
    repeat (4) tick();
    check("rand_drained", 32'(sb.size()), 32'd0);

`ifdef BLOCK_ARB_SWEEP_EN
    begin
      logic [31:0] exp_vec;
      int k;
      logic found;
      exp_vec = 32'd0;
      for (int i = 0; i < 16; i++) begin
        logic [3:0] iv;
        iv = 4'(i);
        exp_vec[2*i +: 2] = model_cell(iv[3:2], iv[1:0]);
      end
      sweep_start = 1'b1;
      @(posedge clk); #1;
      sweep_start = 1'b0;
      k = 0; found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
        @(posedge clk); #1;
        k++;
        check("sweep_gnt", 32'(gnt), 32'd0);
        if (sweep_done) found = 1'b1;
      end
      check("sweep_latency", 32'(k), 32'd17);
      check("sweep_vec_model", sweep_vec, exp_vec);
      check("sweep_vec_const", sweep_vec, 32'hBEEEACCC);
      @(posedge clk); #1;
      check("sweep_done_pulse", 32'(sweep_done), 32'd0);
      check("sweep_vec_hold", sweep_vec, 32'hBEEEACCC);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/block_arbiter.md
# block_arbiter

Shares one instance of the two-input/two-select logic cell `block` between two requesters, and returns each result with a valid/ready handshake. Each transaction captures one requester's operands and select code, evaluates the cell for one cycle, registers the 2-bit result, and holds it until the consumer accepts it. Sits between the control requesters and the shared cell.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  2  level request, one bit per requester (bit 0 = requester 0).
- `opnd0`, `opnd1`  in  2 each  operands `{I0,I1}` for requester 0 and requester 1.
- `sel0`, `sel1`  in  2 each  select codes `{S0,S1}` for requester 0 and requester 1.
- `gnt`  out  2  one-hot, one-cycle pulse: the granted requester's operands were captured.
- `rsp_valid`  out  1  result available.
- `rsp_id`  out  1  index of the requester that owns the result.
- `rsp_data`  out  2  result `{O0,O1}`.
- `rsp_ready`  in  1  consumer accepts the result.

## Operation
- Cell function, with a=S1|I0, b=S0&I1, c=a^b:
  - O0 = S0 ? (a|b) : c
  - O1 = S1 ? c : (a&b)
- FSM states: IDLE, EXEC, RESP, plus SWEEP when `BLOCK_ARB_SWEEP_EN` is defined.
- IDLE, when `req` is nonzero:
  - Pick the winner by round-robin.
  - Latch the winner's opnd/sel into an internal operand register.
  - Set `gnt` to the winner's one-hot code, record the winner in `last`, go to EXEC.
- EXEC:
  - Clear `gnt`.
  - Register the cell output (driven from the operand register) into `rsp_data`.
  - Set `rsp_id` and `rsp_valid`=1, go to RESP.
- RESP: hold `rsp_valid`, `rsp_id` and `rsp_data` stable. On `rsp_valid & rsp_ready`, clear `rsp_valid` and go to IDLE.
- Round-robin rules:
  - If both requesters ask, grant the one that is not `last`.
  - If only one asks, grant it.
  - `last` resets to 1, so requester 0 wins the first tie.
- Requester rules:
  - Hold `req` and operands stable until `gnt` is seen.
  - Deassert `req` in the cycle after `gnt` unless a new transaction is wanted.
  - Operand changes after capture have no effect on the result.
- Requests arriving in EXEC or RESP wait; they are not lost while `req` stays high.

## Timing
- Reset values: `gnt`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, state=IDLE, `last`=1, operand register=0.
- Cycle numbering, with request sampled high at edge N:
  - `gnt` is high during cycle N..N+1.
  - `rsp_valid` rises at edge N+1.
  - Earliest next grant is at the edge after the handshake edge.
- Minimum transaction period is 3 cycles, with `rsp_ready` held high.
- `rsp_ready` is ignored outside RESP.
- `rst` asserted in any state returns all outputs to reset values immediately. An in-flight result is dropped and not replayed.

## Configuration
- Macro: `BLOCK_ARB_SWEEP_EN`.
- Defined: adds the following ports and the SWEEP state.
  - `sweep_start` (in, 1).
  - `sweep_done` (out, 1, one-cycle pulse).
  - `sweep_vec` (out, 32, reset 0).
- Sweep entry: in IDLE, `sweep_start` takes priority over `req` and enters SWEEP with a 4-bit counter i=0.
- Sweep stepping, each cycle:
  - Drive the cell with {I0,I1,S0,S1}=i.
  - Write {O0,O1} into `sweep_vec[2i+1:2i]`.
  - Increment i.
- Sweep exit: after i=15, pulse `sweep_done` and return to IDLE.
- `sweep_vec` holds its value until the next sweep. `gnt` stays 0 throughout SWEEP.
- Not defined: none of these ports or that state exist, and the arbiter behaves identically otherwise.

## Test plan
- Reset: assert `rst` mid-cycle, asynchronously, with no clock edge. Expect all outputs 0 at once and `last`=1.
- Single request: `req`=01, opnd0=2'b01, sel0=2'b10. Expect `gnt`=01 for 1 cycle; one cycle later `rsp_valid`=1, `rsp_id`=0, `rsp_data`=2'b10.
- Tie: `req`=11 from reset, with `rsp_ready`=1. Expect grants in the order 01, 10, 01, with `rsp_id` sequence 0, 1, 0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles while `req`[1] is pending. Expect `rsp_valid` and `rsp_data` stable and `gnt`=0 throughout; requester 1 is granted the edge after the handshake.
- Reset mid-op: assert `rst` in EXEC. Expect `rsp_valid` to stay 0 after release, no spurious `gnt`, and the next request to be served normally.
- Sweep (`BLOCK_ARB_SWEEP_EN`): pulse `sweep_start` in IDLE. Expect `sweep_done` 17 cycles later and `sweep_vec`=32'hBEEEACCC.
